multiplier_share_arbiter: RTL and testbench

- Shares one combinational 8x8 unsigned multiplier (Multiplier_8_Bit) between NUM_REQ requesters.
- Uses a round-robin arbiter, operand capture registers, a registered result and a valid/ready return handshake.
- Sits between the multiply users (e.g. DSP/ALU sequencers) and the single multiplier instance.
- Processes exactly one transaction at a time.

---
 rtl/multiplier_share_arbiter.sv | 173 +++++++++++++++++
 tb/tb_multiplier_share_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_share_arbiter.sv
// ---------------------------------------------------------------------------
// multiplier_share_arbiter
//
// Purpose:
//   Lets NUM_REQ requesters share one combinational 8x8 unsigned multiplier.
//   A round-robin arbiter picks one requester at a time. Its operands are
//   captured and multiplied, and the product is returned through a
//   valid/ready handshake. Only one transaction is in flight at a time.
//
// Ports:
//   Clock_In          system clock, rising-edge active
//   Reset_n_In        asynchronous active-low reset
//   Req_Valid_In      per-requester request valid
//   Req_Data_A_In     packed multiplicands, requester i at [8i+7:8i]
//   Req_Data_B_In     packed multipliers, same packing
//   Req_Ready_Out     per-requester accept, one-hot or zero
//   Result_Valid_Out  product available
//   Result_Out        16-bit product of the served request
//   Result_Id_Out     index of the requester owning Result_Out
//   Result_Ready_In   consumer accepts the result
//   Busy_Out          high whenever a transaction is in progress
// ---------------------------------------------------------------------------

// Shared combinational 8x8 unsigned multiplier.
// Ports: a, b operands; product full 16-bit result.
module Multiplier_8_Bit (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product
);
    assign product = a * b;
endmodule

// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | arbitrating; the round-robin winner is readied and accepted
// ST_MUL     | captured operands drive the multiplier; the product is registered
// ST_RESULT  | result presented; waits for Result_Ready_In
module multiplier_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 Clock_In,
    input  logic                 Reset_n_In,
    input  logic [NUM_REQ-1:0]   Req_Valid_In,
    input  logic [8*NUM_REQ-1:0] Req_Data_A_In,
    input  logic [8*NUM_REQ-1:0] Req_Data_B_In,
    output logic [NUM_REQ-1:0]   Req_Ready_Out,
    output logic                 Result_Valid_Out,
    output logic [15:0]          Result_Out,
    output logic [ID_W-1:0]      Result_Id_Out,
    input  logic                 Result_Ready_In,
    output logic                 Busy_Out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL    = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] grant;
    logic            found;
    logic            accept;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] res_id_q;
    logic [7:0]      op_a_q, op_b_q;
    logic [7:0]      sel_a, sel_b;
    logic [15:0]     product;
    logic [15:0]     result_q;
    int              off;
    int              best_off;

    // Round-robin pick: the winner is the valid requester with the smallest
    // distance above the pointer, counted modulo NUM_REQ.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        best_off = NUM_REQ;
        off      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            off = i - int'(ptr_q);
            if (off < 0) begin
                off = off + NUM_REQ;
            end
            if (Req_Valid_In[i] && (off < best_off)) begin
                best_off = off;
                grant    = ID_W'(i);
                found    = 1'b1;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_a = Req_Data_A_In[8*i +: 8];
                sel_b = Req_Data_B_In[8*i +: 8];
            end
        end
    end

    Multiplier_8_Bit u_mul (
        .a       (op_a_q),
        .b       (op_b_q),
        .product (product)
    );

    always_comb begin
        state_d          = state_q;
        Req_Ready_Out    = '0;
        Result_Valid_Out = 1'b0;
        Busy_Out         = 1'b1;
        accept           = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                Busy_Out = 1'b0;
                if (found) begin
                    // Ready is only raised for a valid requester, so ready
                    // alone implies the handshake completes this cycle.
                    Req_Ready_Out = NUM_REQ'(1) << grant;
                    accept        = 1'b1;
                    state_d       = ST_MUL;
                end
            end
            ST_MUL: begin
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                Result_Valid_Out = 1'b1;
                if (Result_Ready_In) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            id_q     <= '0;
            result_q <= '0;
            res_id_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q <= sel_a;
                op_b_q <= sel_b;
                id_q   <= grant;
                ptr_q  <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
            end
            if (state_q == ST_MUL) begin
                result_q <= product;
                res_id_q <= id_q;
            end
        end
    end

    assign Result_Out    = result_q;
    assign Result_Id_Out = res_id_q;

endmodule

// File: tb/tb_multiplier_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_multiplier_share_arbiter
//
// Self-checking bench for multiplier_share_arbiter (NUM_REQ = 4).
// A transaction-level reference model tracks the arbiter phase and the
// round-robin pointer. It predicts the ready vector and pushes the expected
// {id, A*B} into a scoreboard queue on every accept. A separate monitor pops
// the queue on each result handshake and compares the values.
// ---------------------------------------------------------------------------
module tb_multiplier_share_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_v;
    logic [N-1:0][7:0] req_a;
    logic [N-1:0][7:0] req_b;
    logic [8*N-1:0]   a_in, b_in;
    logic [N-1:0]     ready_out;
    logic             res_valid;
    logic [15:0]      res;
    logic [1:0]       res_id;
    logic             res_ready;
    logic             busy;

    assign a_in = req_a;
    assign b_in = req_b;

    multiplier_share_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .Clock_In         (clk),
        .Reset_n_In       (rst_n),
        .Req_Valid_In     (req_v),
        .Req_Data_A_In    (a_in),
        .Req_Data_B_In    (b_in),
        .Req_Ready_Out    (ready_out),
        .Result_Valid_Out (res_valid),
        .Result_Out       (res),
        .Result_Id_Out    (res_id),
        .Result_Ready_In  (res_ready),
        .Busy_Out         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int prod;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model state: phase 0 idle, 1 multiply, 2 result (the DUT phase after the
    // upcoming rising edge, once updated at the falling edge).
    int   m_phase = 0;
    int   m_ptr   = 0;
    int   m_g;
    int   m_i;
    int   acc_cnt[N];
    int   seen[N];
    int   mode = 0;   // 0: drop valid on accept, 1: re-request, 2: random
    exp_t popped;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, evaluated mid-cycle with stable inputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_ptr   = 0;
            q.delete();
        end else begin
            case (m_phase)
                0: begin
                    m_g = -1;
                    for (int k = 0; k < N; k++) begin
                        m_i = (m_ptr + k) % N;
                        if (m_g < 0 && req_v[m_i]) m_g = m_i;
                    end
                    chk("idle_busy", busy, 0);
                    chk("idle_valid", res_valid, 0);
                    chk("idle_ready", ready_out, (m_g < 0) ? 0 : (1 << m_g));
                    if (m_g >= 0) begin
                        q.push_back('{m_g, int'(req_a[m_g]) * int'(req_b[m_g])});
                        m_ptr = (m_g + 1) % N;
                        acc_cnt[m_g]++;
                        m_phase = 1;
                    end
                end
                1: begin
                    chk("mul_busy", busy, 1);
                    chk("mul_valid", res_valid, 0);
                    chk("mul_ready", ready_out, 0);
                    m_phase = 2;
                end
                default: begin
                    chk("res_busy", busy, 1);
                    chk("res_valid", res_valid, 1);
                    chk("res_ready_out", ready_out, 0);
                    if (res_ready) m_phase = 0;
                end
            endcase
        end
    end

    // Scoreboard monitor: one pop per result handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: result %0d id %0d with no pending request", res, res_id);
            end else begin
                popped = q.pop_front();
                chk("sb_id", res_id, popped.id);
                chk("sb_product", res, popped.prod);
            end
        end
    end

    task automatic cycle();
        bit just;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            just = 1'b0;
            if (acc_cnt[i] != seen[i]) begin
                seen[i] = acc_cnt[i];
                just    = 1'b1;
                case (mode)
                    0: req_v[i] = 1'b0;
                    1: begin
                        req_a[i] = 8'($urandom);
                        req_b[i] = 8'($urandom);
                    end
                    default: begin
                        req_v[i] = ($urandom_range(0, 1) == 1);
                        req_a[i] = 8'($urandom);
                        req_b[i] = 8'($urandom);
                    end
                endcase
            end
            if (mode == 2 && !just) begin
                if (req_v[i]) begin
                    if ($urandom_range(0, 9) == 0) req_v[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_v[i] = 1'b1;
                    req_a[i] = 8'($urandom);
                    req_b[i] = 8'($urandom);
                end
            end
        end
        if (mode == 2) res_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic wait_phase(input int ph, input int maxc);
        int n = 0;
        while (m_phase != ph && n < maxc) begin
            cycle();
            n++;
        end
        chk("wait_phase", m_phase, ph);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_v     = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            acc_cnt[i] = 0;
            seen[i]    = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready_out, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", res, 0);
        chk("rst_id", res_id, 0);
        rst_n = 1'b1;

        // Quiet after reset.
        repeat (10) begin
            cycle();
            chk("quiet_ready", ready_out, 0);
            chk("quiet_valid", res_valid, 0);
            chk("quiet_busy", busy, 0);
            chk("quiet_result", res, 0);
        end

        // All four held valid: grants 0,1,2,3,0, one every 3 cycles.
        mode = 1;
        for (int i = 0; i < N; i++) begin
            req_v[i] = 1'b1;
            req_a[i] = 8'($urandom);
            req_b[i] = 8'($urandom);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", ready_out, 1 << (k % N));
            repeat (3) cycle();
        end
        mode  = 0;
        req_v = '0;

        // Single request from requester 2: 12*13, latency 2.
        req_v[2] = 1'b1;
        req_a[2] = 8'd12;
        req_b[2] = 8'd13;
        #1;
        chk("req2_ready", ready_out, 4'b0100);
        cycle();
        chk("req2_lat1_valid", res_valid, 0);
        cycle();
        chk("req2_lat2_valid", res_valid, 1);
        chk("req2_result", res, 156);
        chk("req2_id", res_id, 2);
        cycle();

        // Extremes of the operand range.
        req_v[0] = 1'b1;
        req_a[0] = 8'hFF;
        req_b[0] = 8'hFF;
        cycle();
        cycle();
        chk("ff_result", res, 16'hFE01);
        cycle();
        req_v[0] = 1'b1;
        req_a[0] = 8'h00;
        req_b[0] = 8'hFF;
        cycle();
        cycle();
        chk("zero_result", res, 0);
        cycle();

        // Backpressure in RESULT with requester 1 waiting.
        res_ready = 1'b0;
        req_v[0]  = 1'b1;
        req_a[0]  = 8'd7;
        req_b[0]  = 8'd9;
        cycle();
        cycle();
        req_v[1] = 1'b1;
        req_a[1] = 8'd5;
        req_b[1] = 8'd6;
        repeat (5) begin
            #1;
            chk("bp_result", res, 63);
            chk("bp_id", res_id, 0);
            chk("bp_valid", res_valid, 1);
            chk("bp_ready_out", ready_out, 0);
            cycle();
        end
        res_ready = 1'b1;
        cycle();
        chk("bp_release_ready", ready_out, 4'b0010);
        repeat (3) cycle();

        // Randomized traffic.
        mode = 2;
        repeat (400) cycle();
        mode      = 0;
        req_v     = '0;
        res_ready = 1'b1;
        wait_phase(0, 20);
        repeat (3) cycle();
        chk("sb_drained", q.size(), 0);

        // Reset asserted during MUL.
        req_v[0] = 1'b1;
        req_a[0] = 8'd200;
        req_b[0] = 8'd3;
        cycle();
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", res_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_result", res, 0);
        chk("arst_id", res_id, 0);
        chk("arst_ready", ready_out, 0);
        req_v[0] = 1'b1;
        req_a[0] = 8'd2;
        req_b[0] = 8'd3;
        req_v[3] = 1'b1;
        req_a[3] = 8'd4;
        req_b[3] = 8'd5;
        cycle();
        cycle();
        rst_n = 1'b1;
        #1;
        chk("post_reset_grant", ready_out, 4'b0001);
        repeat (10) cycle();
        chk("sb_final_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
